// File: rtl/gb_apu_pkg.sv
// Shared constants and helpers for the APU noise channel.
package gb_apu_pkg;

    localparam int DIV_ZERO = 8;
    localparam int FREEZE_SHIFT_DEF = 14;

    typedef logic [2:0] pace_t;

    // Divisor code 0 maps to 8, all other codes to code*16.
    function automatic logic [6:0] divisor_f(input logic [2:0] code);
        if (code == 3'd0) begin
            return 7'(DIV_ZERO);
        end
        return {code, 4'b0000};
    endfunction

endpackage

// File: rtl/gb_apu_noise_lfsr.sv
// Noise LFSR: all-ones load, right shift with xor feedback, optional
// narrow tap and a freeze input that suppresses stepping.
module gb_apu_noise_lfsr #(
    parameter int LFSR_W     = 15,
    parameter int NARROW_TAP = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              tick,
    input  logic              freeze,
    input  logic              narrow,
    output logic [LFSR_W-1:0] lfsr
);

    logic              fb;
    logic [LFSR_W-1:0] stepped;

    always_comb begin
        fb = lfsr[0] ^ lfsr[1];
        stepped = {fb, lfsr[LFSR_W-1:1]};
        if (narrow) begin
            stepped[NARROW_TAP] = fb;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= '1;
        end else if (load) begin
            lfsr <= '1;
        end else if (tick && !freeze) begin
            lfsr <= stepped;
        end
    end

endmodule

// File: rtl/gb_apu_channel_noise_gen.sv
// Channel 4 noise generator with envelope, length counter and DAC gating.
// Define NOISE_LFSR_OBS_EN to expose lfsr_state and lfsr_step for debug.
module gb_apu_channel_noise_gen
    import gb_apu_pkg::*;
#(
    parameter int LFSR_W       = 15,
    parameter int NARROW_TAP   = 6,
    parameter int SHIFT_W      = 4,
    parameter int LEN_W        = 6,
    parameter int VOL_W        = 4,
    parameter int FREEZE_SHIFT = FREEZE_SHIFT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_length_ctr,
    input  logic               clk_vol_env,
    input  logic [LEN_W-1:0]   length,
    input  logic [VOL_W-1:0]   initial_volume,
    input  logic               envelope_increasing,
    input  pace_t              num_envelope_sweeps,
    input  logic [SHIFT_W-1:0] shift_clock_freq,
    input  logic               counter_width,
    input  logic [2:0]         freq_dividing_ratio,
    input  logic               start,
    input  logic               single,
    output logic [VOL_W-1:0]   level,
    output logic               enable
`ifdef NOISE_LFSR_OBS_EN
    ,
    output logic [LFSR_W-1:0]  lfsr_state,
    output logic               lfsr_step
`endif
);

    localparam int TW = 7 + (1 << SHIFT_W) - 1;
    localparam logic [SHIFT_W:0] FREEZE_V = FREEZE_SHIFT[SHIFT_W:0];

    logic              start_q;
    logic              trig;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     reload;
    logic              expire;
    logic              freeze;
    logic              dac_on;
    logic [VOL_W-1:0]  volume;
    pace_t             env_timer;
    logic [LEN_W-1:0]  len_ctr;
    logic [LFSR_W-1:0] lfsr;

    assign reload = {{(TW-7){1'b0}}, divisor_f(freq_dividing_ratio)}
                    << shift_clock_freq;
    assign expire = (timer == '0);
    assign freeze = ({1'b0, shift_clock_freq} >= FREEZE_V);
    assign dac_on = (initial_volume != '0) | envelope_increasing;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            trig    <= 1'b0;
        end else begin
            start_q <= start;
            trig    <= start & ~start_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (trig || expire) begin
            timer <= reload;
        end else begin
            timer <= timer - 1'b1;
        end
    end

    gb_apu_noise_lfsr #(
        .LFSR_W     (LFSR_W),
        .NARROW_TAP (NARROW_TAP)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load   (trig),
        .tick   (expire),
        .freeze (freeze),
        .narrow (counter_width),
        .lfsr   (lfsr)
    );

    // Timer value 0 after reset behaves like 1: the next strobe reloads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            volume    <= '0;
            env_timer <= '0;
        end else if (trig) begin
            volume    <= initial_volume;
            env_timer <= num_envelope_sweeps;
        end else if (clk_vol_env && num_envelope_sweeps != '0) begin
            if (env_timer <= 3'd1) begin
                env_timer <= num_envelope_sweeps;
                if (envelope_increasing && volume != '1) begin
                    volume <= volume + 1'b1;
                end else if (!envelope_increasing && volume != '0) begin
                    volume <= volume - 1'b1;
                end
            end else begin
                env_timer <= env_timer - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_ctr <= '0;
            enable  <= 1'b0;
        end else if (trig) begin
            len_ctr <= length;
            enable  <= dac_on;
        end else begin
            if (clk_length_ctr && single) begin
                len_ctr <= len_ctr + 1'b1;
                if (len_ctr == '1) begin
                    enable <= 1'b0;
                end
            end
            if (!dac_on) begin
                enable <= 1'b0;
            end
        end
    end

    assign level = (enable && !lfsr[0]) ? volume : '0;

`ifdef NOISE_LFSR_OBS_EN
    assign lfsr_state = lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_step <= 1'b0;
        end else begin
            lfsr_step <= expire & ~freeze & ~trig;
        end
    end
`else
    // Upper LFSR bits only leave the block through the debug ports.
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr[LFSR_W-1:1];
`endif

endmodule

// File: tb/tb_gb_apu_channel_noise_gen.sv
// Randomised bench for the noise channel against a behavioural model.
module tb_gb_apu_channel_noise_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_length_ctr;
    logic       clk_vol_env;
    logic [5:0] length;
    logic [3:0] initial_volume;
    logic       envelope_increasing;
    logic [2:0] num_envelope_sweeps;
    logic [3:0] shift_clock_freq;
    logic       counter_width;
    logic [2:0] freq_dividing_ratio;
    logic       start;
    logic       single;
    logic [3:0] level;
    logic       enable;
`ifdef NOISE_LFSR_OBS_EN
    logic [14:0] lfsr_state;
    logic        lfsr_step;
`endif

    int n_vec = 0;
    int n_err = 0;

    int m_lfsr, m_timer, m_vol, m_env, m_len, m_en, m_trig;
    bit m_sq;

    gb_apu_channel_noise_gen dut (
        .clk                 (clk),
        .reset               (reset),
        .clk_length_ctr      (clk_length_ctr),
        .clk_vol_env         (clk_vol_env),
        .length              (length),
        .initial_volume      (initial_volume),
        .envelope_increasing (envelope_increasing),
        .num_envelope_sweeps (num_envelope_sweeps),
        .shift_clock_freq    (shift_clock_freq),
        .counter_width       (counter_width),
        .freq_dividing_ratio (freq_dividing_ratio),
        .start               (start),
        .single              (single),
        .level               (level),
        .enable              (enable)
`ifdef NOISE_LFSR_OBS_EN
        ,
        .lfsr_state          (lfsr_state),
        .lfsr_step           (lfsr_step)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lfsr_adv(input int l, input bit narrow);
        int fb;
        fb = (l ^ (l >> 1)) & 1;
        l = (l >> 1) | (fb << 14);
        if (narrow) l = (l & ~(1 << 6)) | (fb << 6);
        return l;
    endfunction

    function automatic int exp_level();
        return (m_en != 0 && (m_lfsr & 1) == 0) ? m_vol : 0;
    endfunction

    task automatic model_reset();
        m_lfsr = 32'h7FFF;
        m_timer = 0; m_vol = 0; m_env = 0; m_len = 0;
        m_en = 0; m_trig = 0; m_sq = 1'b0;
    endtask

    // Advance the model by one clock using the inputs presented now.
    task automatic model_step();
        int dac, nt, rl, pace;
        dac = (initial_volume != 0 || envelope_increasing) ? 1 : 0;
        pace = int'(num_envelope_sweeps);
        rl = ((freq_dividing_ratio == 0) ? 8
              : int'(freq_dividing_ratio) * 16) << shift_clock_freq;
        nt = (start && !m_sq) ? 1 : 0;
        m_sq = start;
        if (m_trig != 0) begin
            m_lfsr = 32'h7FFF; m_timer = rl; m_vol = int'(initial_volume);
            m_env = pace; m_len = int'(length); m_en = dac;
        end else begin
            if (m_timer == 0) begin
                m_timer = rl;
                if (shift_clock_freq < 14) m_lfsr = lfsr_adv(m_lfsr, counter_width);
            end else begin
                m_timer--;
            end
            if (clk_vol_env && pace != 0) begin
                if (m_env <= 1) begin
                    m_env = pace;
                    if (envelope_increasing) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
                    else m_vol = (m_vol > 0) ? m_vol - 1 : 0;
                end else begin
                    m_env--;
                end
            end
            if (clk_length_ctr && single) begin
                m_len = (m_len + 1) % 64;
                if (m_len == 0) m_en = 0;
            end
            if (dac == 0) m_en = 0;
        end
        m_trig = nt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("level", level, exp_level());
        check("enable", enable, m_en);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic trigger();
        start = 1'b1; tick();
        start = 1'b0; tick();
    endtask

    task automatic vol_strobe();
        clk_vol_env = 1'b1; tick();
        clk_vol_env = 1'b0;
    endtask

    task automatic len_strobe();
        clk_length_ctr = 1'b1; tick();
        clk_length_ctr = 1'b0;
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_level", level, 0);
        check("rst_enable", enable, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; single = 1'b0;
        clk_length_ctr = 1'b0; clk_vol_env = 1'b0;
        length = 6'd0; initial_volume = 4'd15; envelope_increasing = 1'b0;
        num_envelope_sweeps = 3'd0; shift_clock_freq = 4'd0;
        counter_width = 1'b0; freq_dividing_ratio = 3'd0;
        model_reset();
        #3;
        check("reset_level", level, 0);
        check("reset_enable", enable, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        run(4);

        // wide LFSR, code 0, shift 0
        trigger();
        run(300);

        // narrow LFSR over two full periods
        counter_width = 1'b1;
        trigger();
        run(127 * 9 * 2 + 20);
        counter_width = 1'b0;

        // freeze exactly on a reload that would have flipped bit 0
        for (int e = 0; e < 6; e++) begin
            shift_clock_freq = 4'd0;
            freq_dividing_ratio = 3'(e % 2);
            trigger();
            run(int'($urandom_range(0, 120)));
            for (int k = 0; k < 600; k++) begin
                if (m_timer == 0 && m_trig == 0 &&
                    (((m_lfsr >> 1) ^ m_lfsr) & 1) == 1) begin
                    shift_clock_freq = 4'(14 + (e % 2));
                    tick();
                    break;
                end
                tick();
            end
            run(20);
        end
        shift_clock_freq = 4'd0;
        freq_dividing_ratio = 3'd0;

        // envelope down to 0, then up to saturation
        initial_volume = 4'd15; envelope_increasing = 1'b0;
        num_envelope_sweeps = 3'd1;
        trigger();
        for (int i = 0; i < 20; i++) begin
            vol_strobe();
            run(int'($urandom_range(3, 12)));
        end
        initial_volume = 4'd2; envelope_increasing = 1'b1;
        num_envelope_sweeps = 3'd2;
        trigger();
        for (int i = 0; i < 40; i++) begin
            vol_strobe();
            run(int'($urandom_range(3, 12)));
        end

        // length wrap, DAC-off trigger, trigger beside a length strobe
        initial_volume = 4'd15; envelope_increasing = 1'b0;
        num_envelope_sweeps = 3'd0; length = 6'd62; single = 1'b1;
        trigger();
        run(30);
        len_strobe(); run(3);
        len_strobe(); run(3);
        check("len_wrap_enable", enable, 0);
        check("len_wrap_level", level, 0);
        initial_volume = 4'd0;
        trigger();
        run(3);
        check("dac_off_enable", enable, 0);
        initial_volume = 4'd15; length = 6'd60;
        start = 1'b1; tick();
        start = 1'b0; clk_length_ctr = 1'b1; tick();
        clk_length_ctr = 1'b0;
        run(2);
        for (int i = 0; i < 3; i++) begin
            len_strobe(); run(2);
        end
        check("len_hold_enable", enable, 1);
        len_strobe(); run(2);
        check("len_end_enable", enable, 0);

        // randomised operation with an asynchronous reset in the middle
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                initial_volume = 4'($urandom_range(0, 15));
                envelope_increasing = 1'($urandom_range(0, 1));
                num_envelope_sweeps = 3'($urandom_range(0, 7));
                shift_clock_freq = ($urandom_range(0, 9) == 0)
                                   ? 4'($urandom_range(14, 15))
                                   : 4'($urandom_range(0, 2));
                counter_width = 1'($urandom_range(0, 1));
                freq_dividing_ratio = 3'($urandom_range(0, 7));
                single = 1'($urandom_range(0, 1));
                length = 6'($urandom_range(40, 63));
            end
            if ($urandom_range(0, 49) == 0) start = ~start;
            clk_vol_env = ($urandom_range(0, 15) == 0);
            clk_length_ctr = ($urandom_range(0, 15) == 0);
            if (c == 1500) async_reset();
            tick();
        end
        clk_vol_env = 1'b0;
        clk_length_ctr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gb_apu_channel_noise_gen.md
Name: gb_apu_channel_noise_gen

Overview:
Parametrised Channel 4 noise generator. It is the next generation of the fixed 15-bit noise channel.
- Generic LFSR width, narrow-mode tap position and field widths.
- Built-in envelope, length counter and DAC-enable gating.
- Hardware-accurate LFSR clock freeze for large shift amounts.
Sits in the APU channel array, fed by the frame sequencer strobes and NR41–NR44 register fields, driving the mixer.

Parameters:
LFSR_W, 15, LFSR width in bits (≥8)
NARROW_TAP, 6, bit index also loaded with feedback when counter_width=1 (< LFSR_W-1)
SHIFT_W, 4, width of shift_clock_freq
LEN_W, 6, width of the length field
VOL_W, 4, width of volume/level
FREEZE_SHIFT, 14, shift_clock_freq values ≥ this never step the LFSR

Ports:
clk  input  1  CPU clock
reset  input  1  asynchronous, active-low reset (0 = reset)
clk_length_ctr  input  1  one-cycle length strobe (256 Hz)
clk_vol_env  input  1  one-cycle envelope strobe (64 Hz)
length  input  LEN_W  length load value
initial_volume  input  VOL_W  starting envelope volume
envelope_increasing  input  1  envelope direction
num_envelope_sweeps  input  3  envelope pace; 0 = frozen
shift_clock_freq  input  SHIFT_W  divisor shift amount
counter_width  input  1  1 = narrow (short-period) LFSR
freq_dividing_ratio  input  3  divisor code
start  input  1  trigger level; rising edge triggers
single  input  1  length-enable
level  output  VOL_W  channel output
enable  output  1  channel active

Behaviour:
Reset (reset=0, async): lfsr all-ones, freq timer 0, volume 0, env timer 0, length counter 0, enable 0, level 0.

Trigger:
- Trigger = registered rising edge of start; acts one cycle after start rises.
- On trigger:
  - lfsr ← all-ones
  - freq timer ← (div << shift), where div = 8 if code==0 else code·16; width 7+2^SHIFT_W-1 bits, zero-extended
  - volume ← initial_volume
  - env timer ← num_envelope_sweeps
  - length counter ← length
  - enable ← dac_on
- Trigger has priority over any same-cycle timer expiry or strobe.

Frequency timer:
- Down-counts each clk.
- At 0: reloads the divisor formula from the *current* register inputs, and steps the LFSR unless shift_clock_freq ≥ FREEZE_SHIFT. When frozen, the timer still reloads and the LFSR holds.

LFSR step:
- fb = lfsr[0]^lfsr[1].
- Shift right; fb → bit LFSR_W-1.
- If counter_width, fb also overwrites bit NARROW_TAP.

DAC:
- dac_on = (initial_volume≠0) | envelope_increasing.
- dac_on=0 forces enable to 0 on the next clk. A trigger while dac_on=0 leaves enable 0.

Envelope:
- On clk_vol_env with pace≠0: env timer decrements.
- On reaching 1 the timer reloads pace, and volume steps ±1, saturating at 0 and 2^VOL_W-1.
- Pace 0 freezes volume.

Length:
- On clk_length_ctr with single=1: counter increments.
- Wrap from 2^LEN_W-1 to 0 clears enable.
- With single=0, length strobes do not change the counter.

Output:
- level = (enable & ~lfsr[0]) ? volume : 0. Combinational from registers.

Optional Feature:
Macro NOISE_LFSR_OBS_EN.
- Defined: adds output lfsr_state [LFSR_W-1:0] (registered LFSR) and output lfsr_step (1-cycle pulse on each LFSR advance), for debugger/wave-viewer use.
- Undefined: ports absent; behaviour otherwise identical.

Decomposition:
Package gb_apu_pkg holds:
- divisor_f(code) function
- the DIV_ZERO=8 constant
- FREEZE_SHIFT default
- a typedef for the 3-bit pace.

Sub-module gb_apu_noise_lfsr:
- Contents: LFSR register, step, narrow tap, freeze.
- Parameters: LFSR_W, NARROW_TAP.
- Interface: step-enable/load inputs, lfsr output.
Envelope and length counter stay inline.

Test Plan:
- Reset mid-operation: assert reset=0 asynchronously mid-count → level=0, enable=0 immediately, lfsr=7FFF after release.
- Default params, code=0, shift=0, width=0:
  - trigger → first LFSR step 9 clks after trigger cycle
  - lfsr 7FFF→3FFF
  - period sequence length 32767 steps
- counter_width=1: from all-ones → period 127 steps; bit 6 equals bit 14 after each step.
- shift=14, then shift=15 → lfsr stays 7FFF for 10 reloads while timer still counts.
- Envelope:
  - Setup: initial_volume=15, decreasing, pace=1.
  - After 15 clk_vol_env strobes → volume 0 and stays 0.
  - Increasing variant saturates at 15.
- Length and DAC:
  - Setup: length=62, single=1.
  - After 2 length strobes → enable=0, level=0.
  - initial_volume=0 with increasing=0 plus trigger → enable stays 0.
  - Trigger coincident with length strobe → counter=length.
